// File: rtl/md_sched_if.sv
// E-stage multiply/divide issue bus and the HI/LO / stall outputs.
// master = E stage + hazard unit side, slave = md_sched.
interface md_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_D;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, md_op, A, B, md_use_D,
                  input  busy, stall_md, HI, LO);
  modport slave  (input  start, md_op, A, B, md_use_D,
                  output busy, stall_md, HI, LO);
endinterface

// File: rtl/md_sched.sv
// HI/LO owner for the MIPS E stage: computes mult/div results at issue,
// holds them pending for a fixed latency, and requests D-stage stalls meanwhile.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_sched_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, lo_q, pend_hi, pend_lo;
  logic        pend_dz, commit;

  logic op_long, is_mult, is_div, accept, long_acc;
  assign op_long  = (bus.md_op >= 3'd1) && (bus.md_op <= 3'd4);
  assign is_mult  = (bus.md_op == 3'd1) || (bus.md_op == 3'd2);
  assign is_div   = (bus.md_op == 3'd3) || (bus.md_op == 3'd4);
  assign accept   = bus.start && (state_q == IDLE) && (bus.md_op >= 3'd1) && (bus.md_op <= 3'd6);
  assign long_acc = accept && op_long;

  // Results are formed combinationally at issue; only the visibility is delayed.
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] as, bs, bs_safe, q_s, r_s;
  logic [31:0]        bu_safe, q_u, r_u, q_sel, r_sel;
  logic               div_ovf;

  assign prod_s  = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u  = {32'd0, bus.A} * {32'd0, bus.B};
  assign as      = $signed(bus.A);
  assign bs      = $signed(bus.B);
  // Divide-by-zero result is discarded; a safe divisor keeps X out of the datapath.
  assign bs_safe = (bus.B == 32'd0) ? 32'sd1 : bs;
  assign bu_safe = (bus.B == 32'd0) ? 32'd1 : bus.B;
  assign div_ovf = (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF);
  assign q_s     = div_ovf ? 32'sh8000_0000 : as / bs_safe;
  assign r_s     = div_ovf ? 32'sd0 : as % bs_safe;
  assign q_u     = bus.A / bu_safe;
  assign r_u     = bus.A % bu_safe;
  assign q_sel   = (bus.md_op == 3'd3) ? q_s : q_u;
  assign r_sel   = (bus.md_op == 3'd3) ? r_s : r_u;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (long_acc) begin
        state_d = RUN;
        cnt_d   = is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy     = (state_q == RUN);
    bus.stall_md = bus.md_use_D && ((state_q == RUN) || (bus.start && op_long));
    bus.HI       = hi_q;
    bus.LO       = lo_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_dz <= 1'b0;
    end else begin
      if (long_acc) begin
        pend_hi <= is_mult ? ((bus.md_op == 3'd1) ? prod_s[63:32] : prod_u[63:32]) : r_sel;
        pend_lo <= is_mult ? ((bus.md_op == 3'd1) ? prod_s[31:0]  : prod_u[31:0])  : q_sel;
        pend_dz <= is_div && (bus.B == 32'd0);
      end
      if (commit && !pend_dz) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
      if (accept && bus.md_op == 3'd5) hi_q <= bus.A;
      if (accept && bus.md_op == 3'd6) lo_q <= bus.A;
    end
  end
endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: vector table for single ops plus
// hand sequences for reset abort and illegal back-to-back issue.
module tb_md_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  md_sched_if bus();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int illegal_cnt = 0;

  // Monitors that the hazard unit never issues into a busy scheduler.
  always @(posedge clk)
    if (!reset && bus.start && bus.busy) illegal_cnt <= illegal_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, then count busy cycles (bounded) checking stall_md.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, output int cyc);
    logic stall_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b; bus.md_use_D = use_d;
    #1 chk("stall_issue", {31'd0, bus.stall_md}, {31'd0, use_d && op >= 3'd1 && op <= 3'd4});
    @(posedge clk);
    #1 bus.start = 1'b0; bus.md_op = 3'd0;
    cyc = 0;
    stall_ok = 1'b1;
    @(negedge clk);
    while (bus.busy && cyc < 20) begin
      cyc++;
      if (bus.stall_md !== use_d) stall_ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_busy", {31'd0, stall_ok}, 32'd1);
    chk("stall_fall", {31'd0, bus.stall_md}, 32'd0);
    bus.md_use_D = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        use_d;
    int          cyc;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t vecs[13];
  int cyc;

  initial begin
    bus.start = 1'b0; bus.md_op = 3'd0; bus.A = 32'd0; bus.B = 32'd0; bus.md_use_D = 1'b1;
    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'd2,         1'b1, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,         1'b0, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,         1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2,         1'b0, 10, 32'h00000001, 32'h7FFFFFFC};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd5, 32'h00000011, 32'd0,         1'b1, 0,  32'h00000011, 32'h80000000};
    vecs[6]  = '{3'd6, 32'h00000022, 32'd0,         1'b0, 0,  32'h00000011, 32'h00000022};
    vecs[7]  = '{3'd3, 32'h00000005, 32'd0,         1'b1, 10, 32'h00000011, 32'h00000022};
    vecs[8]  = '{3'd0, 32'h12345678, 32'd3,         1'b0, 0,  32'h00000011, 32'h00000022};
    vecs[9]  = '{3'd7, 32'h12345678, 32'd3,         1'b1, 0,  32'h00000011, 32'h00000022};
    vecs[10] = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[11] = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{3'd2, 32'h00010000, 32'h00010000, 1'b0, 5,  32'h00000001, 32'h00000000};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_md}, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;
    bus.md_use_D = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_hi", i), bus.HI, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), bus.LO, vecs[i].lo);
    end

    // Reset during the 3rd busy cycle of a div aborts it.
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.md_op = 3'd0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    chk("abort_lo", bus.LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd6, 32'h1234, 32'd0, 1'b0, cyc);
    chk("mtlo_cycles", cyc, 0);
    chk("mtlo_lo", bus.LO, 32'h1234);
    chk("mtlo_hi", bus.HI, 32'd0);

    // Illegal issue of a div while a mult is in flight must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'd3; bus.B = 32'd4;
    @(posedge clk);
    #1 bus.md_op = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    cyc = 0;
    while (bus.busy && cyc < 20) begin
      cyc++;
      @(negedge clk);
      bus.start = 1'b0; bus.md_op = 3'd0;
    end
    chk("b2b_cycles", cyc, 5);
    chk("b2b_hi", bus.HI, 32'd0);
    chk("b2b_lo", bus.LO, 32'd12);
    chk("illegal_seen", illegal_cnt, 1);
    run_op(3'd3, 32'd100, 32'd7, 1'b1, cyc);
    chk("div2_cycles", cyc, 10);
    chk("div2_hi", bus.HI, 32'd2);
    chk("div2_lo", bus.LO, 32'd14);
    chk("illegal_final", illegal_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler for the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E stage and owns the HI/LO registers.
- Models fixed multi-cycle latency with a busy counter and raises the D-stage stall request while an md instruction would collide with an in-flight operation.
- Sits beside the ALU in E; HI/LO feed the mfhi/mflo result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  E-stage instruction is an md operation this cycle
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
- A  input  32  rs operand (forwarded value at E)
- B  input  32  rt operand (forwarded value at E)
- md_use_D  input  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- busy  output  1  long operation in flight
- stall_md  output  1  combinational stall request to hazard unit
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (async): busy=0, cnt=0, HI=0, LO=0, pending regs=0; stall_md=0 once reset is seen. Reset mid-operation aborts the operation; HI/LO are not updated.
- Accept: an operation is accepted on a rising edge when start=1, busy=0, and md_op is 1..6.
  - md_op 0 or 7 is ignored.
  - start while busy=1 is ignored; the hazard unit guarantees this never happens, and a bench assertion checks it.
- mult/multu on accept:
  - Compute the 64-bit product at once: signed for op 1, unsigned for op 2.
  - Latch {hi,lo} into the pending regs; cnt<=MULT_CYCLES; busy<=1.
- div/divu on accept:
  - Quotient goes to pending LO, remainder to pending HI.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - cnt<=DIV_CYCLES; busy<=1.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - B==0: no result is produced; HI/LO keep their old values. The busy timing is still applied.
- mthi/mtlo on accept:
  - HI<=A (op 5) or LO<=A (op 6) on the same edge.
  - No busy; cnt unchanged.
- Countdown:
  - While busy: cnt decrements by 1 each edge.
  - On the edge where cnt==1: HI/LO<=pending (unless div-by-zero), cnt<=0, busy<=0.
  - busy is therefore high for exactly N cycles after the accept edge.
  - HI/LO show new values in the cycle busy falls.
- Counter/state: cnt is 4 bits; the states are IDLE (busy=0) and RUN (busy=1). RUN goes to IDLE only via cnt==1 or reset.
- stall_md = md_use_D & (busy | (start & md_op in 1..4)). This is combinational, so an md instruction in D directly behind a long op stalls from the issue cycle.
- HI/LO outputs are registered only. There is no HI/LO bypass: mfhi in D stalls until busy=0. mthi followed by mfhi is resolved by the normal E/M forwarding path, not by this block.
- Pending registers hold their values when idle. A new long op overwrites them only on accept.

Test Plan:
- Reset then mult A=0xFFFFFFFF, B=2 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. With multu on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with the same operands -> LO=0x7FFFFFFC, HI=1.
- div A=5, B=0 with HI=0x11, LO=0x22 preset via mthi/mtlo -> busy 10 cycles; HI/LO remain 0x11/0x22.
- mult issued with md_use_D=1 (mflo behind it) -> stall_md=1 in the issue cycle and for all 5 busy cycles; stall_md=0 in the cycle busy falls, with LO already valid.
- Assert reset at the 3rd busy cycle of a div -> busy=0, HI=LO=0 immediately. A mtlo A=0x1234 after release -> LO=0x1234 next edge, busy stays 0.
- Back-to-back: mult accepted, then start=1 with div while busy -> div ignored, and the assertion flags the illegal issue. The next div after busy falls completes normally.
